// File: rtl/fta_req_arbiter_if.sv
// Bundle of the requester, downstream command and response signals of the FTA request arbiter.
// The master modport is the arbiter's view. The slave modport is the view of the requesters and the downstream port.
interface fta_req_arbiter_if #(
  parameter int CHANNELS = 8,
  parameter int AW       = 32,
  parameter int DW       = 128,
  parameter int TIDW     = 8
);
  localparam int CW = $clog2(CHANNELS);

  logic [CHANNELS-1:0]      req_cyc;
  logic [CHANNELS-1:0]      req_we;
  logic [CHANNELS*AW-1:0]   req_adr;
  logic [CHANNELS*DW-1:0]   req_dat;
  logic [CHANNELS*TIDW-1:0] req_tid;
  logic [CHANNELS-1:0]      req_ack;

  logic                     m_cyc;
  logic                     m_we;
  logic [AW-1:0]            m_adr;
  logic [DW-1:0]            m_dat;
  logic [TIDW-1:0]          m_tid;
  logic [CW-1:0]            m_cid;
  logic                     m_stall;

  logic                     s_ack;
  logic [CW-1:0]            s_cid;
  logic                     s_err;
  logic [TIDW-1:0]          s_tid;
  logic [DW-1:0]            s_dat;

  logic [CHANNELS-1:0]      resp_ack;
  logic                     resp_err;
  logic [TIDW-1:0]          resp_tid;
  logic [DW-1:0]            resp_dat;
  logic                     orphan;

  modport master (
    input  req_cyc, req_we, req_adr, req_dat, req_tid,
    output req_ack,
    output m_cyc, m_we, m_adr, m_dat, m_tid, m_cid,
    input  m_stall,
    input  s_ack, s_cid, s_err, s_tid, s_dat,
    output resp_ack, resp_err, resp_tid, resp_dat, orphan
  );

  modport slave (
    output req_cyc, req_we, req_adr, req_dat, req_tid,
    input  req_ack,
    input  m_cyc, m_we, m_adr, m_dat, m_tid, m_cid,
    output m_stall,
    output s_ack, s_cid, s_err, s_tid, s_dat,
    input  resp_ack, resp_err, resp_tid, resp_dat, orphan
  );
endinterface

// File: rtl/fta_req_arbiter.sv
// Round-robin arbiter: shares one FTA master port among CHANNELS requesters, tags commands with cid,
// caps outstanding commands per channel and routes registered responses back by cid.
module fta_req_arbiter #(
  parameter int CHANNELS = 8,
  parameter int AW       = 32,
  parameter int DW       = 128,
  parameter int TIDW     = 8,
  parameter int MAXOUT   = 4
) (
  input  logic            clk,
  input  logic            rst,
  fta_req_arbiter_if.master bus
);
  localparam int CW  = $clog2(CHANNELS);
  localparam int OCW = $clog2(MAXOUT + 1);
  localparam logic [OCW-1:0]      MAX_CNT  = OCW'(MAXOUT);
  localparam logic [CHANNELS-1:0] ONE_HOT0 = CHANNELS'(1);

  typedef enum logic {S_IDLE, S_ISSUE} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         last_q, last_d;
  logic [OCW-1:0]        outst_q [CHANNELS];
  logic [OCW-1:0]        outst_d [CHANNELS];

  logic                  m_cyc_q, m_cyc_d;
  logic                  m_we_q, m_we_d;
  logic [AW-1:0]         m_adr_q, m_adr_d;
  logic [DW-1:0]         m_dat_q, m_dat_d;
  logic [TIDW-1:0]       m_tid_q, m_tid_d;
  logic [CW-1:0]         m_cid_q, m_cid_d;
  logic [CHANNELS-1:0]   req_ack_q, req_ack_d;

  logic [CHANNELS-1:0]   resp_ack_q, resp_ack_d;
  logic                  resp_err_q, resp_err_d;
  logic [TIDW-1:0]       resp_tid_q, resp_tid_d;
  logic [DW-1:0]         resp_dat_q, resp_dat_d;
  logic                  orphan_q, orphan_d;

  logic                  accept;
  logic [CHANNELS-1:0]   elig;
  logic                  grant_valid;
  logic [CW-1:0]         grant_idx;
  logic [CW-1:0]         rr_idx;
  logic                  load;

  assign accept = (state_q == S_ISSUE) && !bus.m_stall;

  // The channel being accepted this edge is masked, so it is never re-granted while its req_ack is high.
  always_comb begin
    elig = bus.req_cyc;
    for (int n = 0; n < CHANNELS; n++) begin
      if (outst_q[n] >= MAX_CNT) elig[n] = 1'b0;
    end
    if (accept) elig[m_cid_q] = 1'b0;
  end

  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    rr_idx      = '0;
    for (int i = 1; i <= CHANNELS; i++) begin
      rr_idx = last_q + CW'(i);
      if (!grant_valid && elig[rr_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = rr_idx;
      end
    end
  end

  // NOTE: every *_d gets its default before the case so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    m_cyc_d   = m_cyc_q;
    m_we_d    = m_we_q;
    m_adr_d   = m_adr_q;
    m_dat_d   = m_dat_q;
    m_tid_d   = m_tid_q;
    m_cid_d   = m_cid_q;
    req_ack_d = '0;
    load      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          load    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          if (grant_valid) begin
            load = 1'b1;
          end else begin
            m_cyc_d = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      m_cyc_d   = 1'b1;
      m_we_d    = bus.req_we[grant_idx];
      m_adr_d   = bus.req_adr[int'(grant_idx)*AW +: AW];
      m_dat_d   = bus.req_dat[int'(grant_idx)*DW +: DW];
      m_tid_d   = bus.req_tid[int'(grant_idx)*TIDW +: TIDW];
      m_cid_d   = grant_idx;
      last_d    = grant_idx;
      req_ack_d = ONE_HOT0 << grant_idx;
    end
  end

  // An acceptance and a response on the same channel in one edge cancel out.
  always_comb begin
    for (int n = 0; n < CHANNELS; n++) begin
      outst_d[n] = outst_q[n];
      if (accept && (m_cid_q == CW'(n))) begin
        if (!(bus.s_ack && (bus.s_cid == CW'(n)))) outst_d[n] = outst_q[n] + OCW'(1);
      end else if (bus.s_ack && (bus.s_cid == CW'(n)) && (outst_q[n] != '0)) begin
        outst_d[n] = outst_q[n] - OCW'(1);
      end
    end
  end

  always_comb begin
    resp_ack_d = bus.s_ack ? (ONE_HOT0 << bus.s_cid) : '0;
    resp_err_d = bus.s_ack & bus.s_err;
    resp_tid_d = bus.s_ack ? bus.s_tid : '0;
    resp_dat_d = bus.s_ack ? bus.s_dat : '0;
    orphan_d   = bus.s_ack && (outst_q[bus.s_cid] == '0);
  end

  // NOTE: the outstanding counters are control state and must be reset; the loop resets every entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      last_q     <= CW'(CHANNELS - 1);
      for (int n = 0; n < CHANNELS; n++) outst_q[n] <= '0;
      m_cyc_q    <= 1'b0;
      m_we_q     <= 1'b0;
      m_adr_q    <= '0;
      m_dat_q    <= '0;
      m_tid_q    <= '0;
      m_cid_q    <= '0;
      req_ack_q  <= '0;
      resp_ack_q <= '0;
      resp_err_q <= 1'b0;
      resp_tid_q <= '0;
      resp_dat_q <= '0;
      orphan_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      for (int n = 0; n < CHANNELS; n++) outst_q[n] <= outst_d[n];
      m_cyc_q    <= m_cyc_d;
      m_we_q     <= m_we_d;
      m_adr_q    <= m_adr_d;
      m_dat_q    <= m_dat_d;
      m_tid_q    <= m_tid_d;
      m_cid_q    <= m_cid_d;
      req_ack_q  <= req_ack_d;
      resp_ack_q <= resp_ack_d;
      resp_err_q <= resp_err_d;
      resp_tid_q <= resp_tid_d;
      resp_dat_q <= resp_dat_d;
      orphan_q   <= orphan_d;
    end
  end

  assign bus.req_ack  = req_ack_q;
  assign bus.m_cyc    = m_cyc_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_adr    = m_adr_q;
  assign bus.m_dat    = m_dat_q;
  assign bus.m_tid    = m_tid_q;
  assign bus.m_cid    = m_cid_q;
  assign bus.resp_ack = resp_ack_q;
  assign bus.resp_err = resp_err_q;
  assign bus.resp_tid = resp_tid_q;
  assign bus.resp_dat = resp_dat_q;
  assign bus.orphan   = orphan_q;
endmodule

// File: tb/tb_fta_req_arbiter.sv
// Directed bench for fta_req_arbiter: a table of single-grant vectors plus hand-written multi-cycle sequences.
module tb_fta_req_arbiter;
  localparam int CHANNELS = 8;
  localparam int AW       = 32;
  localparam int DW       = 128;
  localparam int TIDW     = 8;
  localparam int MAXOUT   = 2;

  logic clk;
  logic rst;
  int   n_cmp  = 0;
  int   n_fail = 0;

  fta_req_arbiter_if #(.CHANNELS(CHANNELS), .AW(AW), .DW(DW), .TIDW(TIDW)) bif ();

  fta_req_arbiter #(
    .CHANNELS(CHANNELS), .AW(AW), .DW(DW), .TIDW(TIDW), .MAXOUT(MAXOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [7:0]   mask;
    int           cid;
    logic [31:0]  adr;
    logic [7:0]   tid;
    logic         we;
    logic [127:0] dat;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outst(input int n);
    return 8'(dut.outst_q[n]);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bif.req_cyc = '0;
    bif.req_we  = '0;
    bif.req_adr = '0;
    bif.req_dat = '0;
    bif.req_tid = '0;
    bif.m_stall = 1'b0;
    bif.s_ack   = 1'b0;
    bif.s_cid   = '0;
    bif.s_err   = 1'b0;
    bif.s_tid   = '0;
    bif.s_dat   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [31:0] adr, input logic [7:0] tid, input logic we);
    bif.req_adr[ch*AW +: AW]     = adr;
    bif.req_tid[ch*TIDW +: TIDW] = tid;
    bif.req_dat[ch*DW +: DW]     = {96'h0, adr};
    bif.req_we[ch]               = we;
  endtask

  task automatic respond(input int ch, input logic [127:0] dat, input logic [7:0] tid, input logic err);
    bif.s_ack = 1'b1;
    bif.s_cid = 3'(ch);
    bif.s_dat = dat;
    bif.s_tid = tid;
    bif.s_err = err;
  endtask

  initial begin
    int fair_order [6];

    vecs[0] = '{mask: 8'h08, cid: 3, adr: 32'h0000_1000, tid: 8'h21, we: 1'b0, dat: 128'h1111};
    vecs[1] = '{mask: 8'hFF, cid: 4, adr: 32'h0000_2004, tid: 8'h42, we: 1'b1, dat: 128'h2222};
    vecs[2] = '{mask: 8'h11, cid: 0, adr: 32'h0000_3000, tid: 8'h03, we: 1'b0, dat: 128'h3333};
    vecs[3] = '{mask: 8'h01, cid: 0, adr: 32'h0000_4000, tid: 8'h04, we: 1'b1, dat: 128'h4444};
    vecs[4] = '{mask: 8'h81, cid: 7, adr: 32'h0000_5007, tid: 8'h57, we: 1'b0, dat: 128'h5555};
    vecs[5] = '{mask: 8'h81, cid: 0, adr: 32'h0000_6000, tid: 8'h60, we: 1'b1, dat: 128'h6666};
    vecs[6] = '{mask: 8'h06, cid: 1, adr: 32'h0000_7001, tid: 8'h71, we: 1'b0, dat: 128'h7777};
    vecs[7] = '{mask: 8'h80, cid: 7, adr: 32'hFFFF_FFF7, tid: 8'hF7, we: 1'b1, dat: 128'hFFFF};
    fair_order = '{0, 2, 5, 0, 2, 5};

    // Reset values, sampled while reset is held.
    clear_inputs();
    rst = 1'b1;
    step();
    check("rst_m_cyc", bif.m_cyc, 0);
    check("rst_m_we", bif.m_we, 0);
    check("rst_m_adr", bif.m_adr, 0);
    check("rst_m_cid", bif.m_cid, 0);
    check("rst_req_ack", bif.req_ack, 0);
    check("rst_resp_ack", bif.resp_ack, 0);
    check("rst_resp_dat", bif.resp_dat, 0);
    check("rst_orphan", bif.orphan, 0);
    step();
    rst = 1'b0;

    // Table: one grant, accept and response per vector; round-robin pointer carries across vectors.
    for (int v = 0; v < 8; v++) begin
      for (int n = 0; n < CHANNELS; n++) set_req(n, 32'hBAD0_0000 | 32'(n), 8'hEE, 1'b0);
      set_req(vecs[v].cid, vecs[v].adr, vecs[v].tid, vecs[v].we);
      bif.req_cyc = vecs[v].mask;
      step();
      check($sformatf("v%0d_grant_m_cyc", v), bif.m_cyc, 1);
      check($sformatf("v%0d_m_cid", v), bif.m_cid, vecs[v].cid);
      check($sformatf("v%0d_req_ack", v), bif.req_ack, 8'(1) << vecs[v].cid);
      check($sformatf("v%0d_m_adr", v), bif.m_adr, vecs[v].adr);
      check($sformatf("v%0d_m_tid", v), bif.m_tid, vecs[v].tid);
      check($sformatf("v%0d_m_we", v), bif.m_we, vecs[v].we);
      bif.req_cyc = '0;
      step();
      check($sformatf("v%0d_idle_m_cyc", v), bif.m_cyc, 0);
      check($sformatf("v%0d_req_ack_pulse", v), bif.req_ack, 0);
      check($sformatf("v%0d_outst_inc", v), outst(vecs[v].cid), 1);
      respond(vecs[v].cid, vecs[v].dat, vecs[v].tid, 1'b0);
      step();
      bif.s_ack = 1'b0;
      check($sformatf("v%0d_resp_ack", v), bif.resp_ack, 8'(1) << vecs[v].cid);
      check($sformatf("v%0d_resp_dat", v), bif.resp_dat, vecs[v].dat);
      check($sformatf("v%0d_resp_tid", v), bif.resp_tid, vecs[v].tid);
      check($sformatf("v%0d_orphan", v), bif.orphan, 0);
      check($sformatf("v%0d_outst_dec", v), outst(vecs[v].cid), 0);
    end

    // Fairness: 0, 2, 5 back-to-back until each hits MAXOUT=2.
    do_reset();
    bif.req_cyc = 8'h25;
    for (int k = 0; k < 6; k++) begin
      step();
      check($sformatf("fair%0d_m_cyc", k), bif.m_cyc, 1);
      check($sformatf("fair%0d_m_cid", k), bif.m_cid, fair_order[k]);
      check($sformatf("fair%0d_req_ack", k), bif.req_ack, 8'(1) << fair_order[k]);
    end
    step();
    check("fair_limit_m_cyc", bif.m_cyc, 0);
    check("fair_outst0", outst(0), 2);
    check("fair_outst2", outst(2), 2);
    check("fair_outst5", outst(5), 2);
    step();
    check("fair_blocked_m_cyc", bif.m_cyc, 0);
    bif.req_cyc = '0;

    // Outstanding limit: channel 4 twice, then blocked while 6 is served, then released by a response.
    do_reset();
    set_req(4, 32'h4444_0000, 8'h44, 1'b0);
    set_req(6, 32'h6666_0000, 8'h66, 1'b1);
    bif.req_cyc = 8'h10;
    step();
    check("lim_g1_cid", bif.m_cid, 4);
    step();
    check("lim_a1_m_cyc", bif.m_cyc, 0);
    step();
    check("lim_g2_cid", bif.m_cid, 4);
    check("lim_g2_m_cyc", bif.m_cyc, 1);
    step();
    check("lim_outst4", outst(4), 2);
    bif.req_cyc = 8'h50;
    step();
    check("lim_g6_cid", bif.m_cid, 6);
    check("lim_g6_req_ack", bif.req_ack, 8'h40);
    bif.req_cyc = 8'h10;
    step();
    check("lim_blocked_m_cyc", bif.m_cyc, 0);
    respond(4, 128'h4, 8'h44, 1'b0);
    step();
    bif.s_ack = 1'b0;
    check("lim_resp_orphan", bif.orphan, 0);
    check("lim_outst4_dec", outst(4), 1);
    step();
    check("lim_regrant_m_cyc", bif.m_cyc, 1);
    check("lim_regrant_cid", bif.m_cid, 4);
    bif.req_cyc = '0;

    // Stall hold: channel 1 held in ISSUE for 4 stalled edges.
    do_reset();
    set_req(1, 32'hA5A5_0001, 8'h11, 1'b1);
    bif.m_stall = 1'b1;
    bif.req_cyc = 8'h02;
    step();
    check("stall_grant_cid", bif.m_cid, 1);
    bif.req_cyc = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("stall%0d_m_cyc", k), bif.m_cyc, 1);
      check($sformatf("stall%0d_m_adr", k), bif.m_adr, 32'hA5A5_0001);
      check($sformatf("stall%0d_req_ack", k), bif.req_ack, 0);
      check($sformatf("stall%0d_outst1", k), outst(1), 0);
    end
    bif.m_stall = 1'b0;
    step();
    check("stall_done_m_cyc", bif.m_cyc, 0);
    check("stall_done_outst1", outst(1), 1);

    // Response routing and orphan detection on channel 5.
    do_reset();
    bif.req_cyc = 8'h20;
    step();
    bif.req_cyc = '0;
    step();
    check("rr_outst5", outst(5), 1);
    respond(5, 128'hDEAD, 8'h55, 1'b1);
    step();
    check("rr_resp_ack", bif.resp_ack, 8'h20);
    check("rr_resp_dat", bif.resp_dat, 128'hDEAD);
    check("rr_resp_err", bif.resp_err, 1);
    check("rr_orphan", bif.orphan, 0);
    check("rr_outst5_zero", outst(5), 0);
    step();
    bif.s_ack = 1'b0;
    check("rr_rep_orphan", bif.orphan, 1);
    check("rr_rep_resp_ack", bif.resp_ack, 8'h20);
    check("rr_rep_outst5", outst(5), 0);
    step();
    check("rr_clear_resp_ack", bif.resp_ack, 0);
    check("rr_clear_resp_dat", bif.resp_dat, 0);
    check("rr_clear_resp_err", bif.resp_err, 0);
    check("rr_clear_orphan", bif.orphan, 0);

    // Simultaneous acceptance and response on channel 2.
    do_reset();
    bif.req_cyc = 8'h04;
    step();
    bif.req_cyc = '0;
    step();
    check("sim_outst2_pre", outst(2), 1);
    bif.req_cyc = 8'h04;
    step();
    check("sim_grant_cid", bif.m_cid, 2);
    bif.req_cyc = '0;
    respond(2, 128'hC0DE, 8'h22, 1'b0);
    step();
    bif.s_ack = 1'b0;
    check("sim_outst2_same", outst(2), 1);
    check("sim_resp_ack", bif.resp_ack, 8'h04);
    check("sim_orphan", bif.orphan, 0);
    check("sim_m_cyc", bif.m_cyc, 0);

    // Reset asserted mid-ISSUE, then a late response for the lost command.
    bif.m_stall = 1'b1;
    bif.req_cyc = 8'h02;
    step();
    check("mid_issue_m_cyc", bif.m_cyc, 1);
    bif.req_cyc = '0;
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_m_cyc", bif.m_cyc, 0);
    check("mid_rst_outst2", outst(2), 0);
    step();
    rst = 1'b0;
    bif.m_stall = 1'b0;
    respond(1, 128'hBEEF, 8'h11, 1'b0);
    step();
    bif.s_ack = 1'b0;
    check("late_orphan", bif.orphan, 1);
    check("late_resp_ack", bif.resp_ack, 8'h02);
    check("late_resp_dat", bif.resp_dat, 128'hBEEF);
    step();
    check("late_orphan_pulse", bif.orphan, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fta_req_arbiter.md
# fta_req_arbiter

Round-robin request arbiter that shares one downstream FTA master port among CHANNELS requesters and routes returning responses back to the originating channel by channel ID. It sits on the requester side of the per-channel response buffer: it tags each issued command with the winning channel index as cid, and it limits outstanding transactions per channel so that buffer slots cannot be overrun.

## Interface
- CHANNELS, 8: number of requesters, power of two, 2..16.
- AW, 32: address width.
- DW, 128: data width.
- TIDW, 8: transaction ID width.
- MAXOUT, 4: maximum outstanding commands per channel, 1..15.
- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  reset. Asynchronous, active-high.
- req_cyc  in  CHANNELS  request valid, one bit per channel; held until acked.
- req_we  in  CHANNELS  write enable per channel.
- req_adr  in  CHANNELS*AW  address; channel n occupies bits [n*AW +: AW].
- req_dat  in  CHANNELS*DW  write data, packed the same way.
- req_tid  in  CHANNELS*TIDW  transaction ID, packed the same way.
- req_ack  out  CHANNELS  one-cycle pulse: command captured.
- m_cyc, m_we  out  1  downstream command valid and write enable.
- m_adr, m_dat, m_tid  out  AW/DW/TIDW  downstream command fields.
- m_cid  out  $clog2(CHANNELS)  index of the winning channel.
- m_stall  in  1  downstream not accepting this cycle.
- s_ack  in  1  downstream response valid.
- s_cid  in  $clog2(CHANNELS)  response channel.
- s_err  in  1  response error.
- s_tid  in  TIDW  response transaction ID.
- s_dat  in  DW  response data.
- resp_ack  out  CHANNELS  one-hot response strobe.
- resp_err  out  1  response error, shared across channels.
- resp_tid  out  TIDW  response transaction ID, shared across channels.
- resp_dat  out  DW  response data, shared across channels.
- orphan  out  1  pulse: a response arrived for a channel whose outstanding count was 0.

## Operation
- Eligible channel n: req_cyc[n] is set and outst[n] < MAXOUT.
- Round-robin: the search starts at last+1 (mod CHANNELS), and the first eligible channel wins. last is updated to the winner on capture.
- FSM IDLE:
  - With any channel eligible: load the m_* registers from the winner, set m_cid=winner, m_cyc=1, pulse req_ack[winner], then go to ISSUE.
  - With no channel eligible: stay in IDLE.
- FSM ISSUE: hold m_* stable while m_stall=1. On the first edge with m_stall=0, the command is accepted:
  - outst[m_cid] increments.
  - If another channel is eligible (the just-accepted channel's req_cyc is ignored this cycle), load it immediately and stay in ISSUE (back-to-back).
  - Otherwise m_cyc=0 and go to IDLE.
- Response path is registered, one stage:
  - Each edge: resp_ack <= s_ack ? onehot(s_cid) : 0. resp_err, resp_tid and resp_dat are loaded from s_* when s_ack=1, else cleared to 0.
  - On s_ack: outst[s_cid] decrements, saturating at 0.
  - If outst[s_cid] was already 0, the response is still routed and orphan pulses for one cycle.
- Simultaneous acceptance and response on the same channel: outst is unchanged.
- Counter width is $clog2(MAXOUT+1). Counters never exceed MAXOUT.

## Timing
- Reset values:
  - m_cyc=0, m_we=0, m_adr/m_dat/m_tid/m_cid=0.
  - req_ack=0, resp_ack=0, resp_err=0, resp_tid=0, resp_dat=0, orphan=0.
  - All outst=0, last=CHANNELS-1 (so channel 0 wins first), FSM=IDLE.
- Reset asserted mid-transaction: m_cyc drops asynchronously. In-flight responses arriving after reset release are routed and flagged orphan.
- Grant latency:
  - req_cyc seen in IDLE: m_cyc and req_ack are both high the next cycle.
  - The requester updates or drops its request by the following edge. It is never re-granted in the cycle req_ack is high.
- Issue latency: one command per cycle sustained when m_stall=0 and requesters are eligible; acceptance is on the edge where m_cyc=1 and m_stall=0.
- Response latency: s_ack to resp_ack is one cycle.

## Test plan
- Single request: reset, then req_cyc[3]=1 with adr=0x1000 and tid=0x21.
  - Next cycle: m_cyc=1, m_cid=3, m_adr=0x1000, req_ack=0x08.
  - With m_stall=0: accepted, outst[3]=1, m_cyc=0 the following cycle.
- Fairness: channels 0, 2 and 5 request continuously with m_stall=0 and MAXOUT large enough. Grant order is 0,2,5,0,2,5 with no idle cycles after the first grant.
- Stall hold: m_stall=1 for 4 cycles during ISSUE on channel 1. m_* stay stable, no extra req_ack, and outst[1] increments only after m_stall falls.
- Outstanding limit, MAXOUT=2: channel 4 issues twice with no responses, so its third request is blocked while channel 6 is served. After one s_ack with s_cid=4, channel 4 is granted again.
- Response routing: s_ack=1, s_cid=5, s_dat=0xDEAD, s_err=1 with outst[5]=1.
  - Next cycle: resp_ack=0x20, resp_dat=0xDEAD, resp_err=1, outst[5]=0.
  - A repeat of the same response gives orphan=1 and outst stays 0.
- Simultaneous events: channel 2 is accepted on the same edge as an s_ack for channel 2, so outst[2] is unchanged. Asserting rst mid-ISSUE clears m_cyc and all counters immediately.
